// File: rtl/i_type_pkg.sv
// Shared types and decode helpers for the OP-IMM decode stage.
package i_type_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    ADDI      = 3'd0,
    SLLI      = 3'd1,
    SLTI      = 3'd2,
    SLTIU     = 3'd3,
    XORI      = 3'd4,
    SRLI_SRAI = 3'd5,
    ORI       = 3'd6,
    ANDI      = 3'd7
  } funct3_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  typedef struct packed {
    logic [6:0]  opcode;
    funct3_e     funct3;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        illegal;
  } dec_t;

  // Shifts only allow a zero upper immediate, except SRAI which sets bit 30.
  function automatic logic is_legal_opimm(input logic [31:0] instr);
    logic shamt_ok;
    case (funct3_e'(instr[14:12]))
      SLLI:      shamt_ok = (instr[31:25] == 7'h00);
      SRLI_SRAI: shamt_ok = (instr[31:25] == 7'h00) || (instr[31:25] == 7'h20);
      default:   shamt_ok = 1'b1;
    endcase
    return (instr[6:0] == OP_IMM) && shamt_ok;
  endfunction

  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    d.opcode  = instr[6:0];
    d.funct3  = funct3_e'(instr[14:12]);
    d.imm     = instr[31:20];
    d.rd      = instr[11:7];
    d.rs1     = instr[19:15];
    d.illegal = !is_legal_opimm(instr);
    return d;
  endfunction

endpackage

// File: rtl/i_decode_stage_if.sv
// Instruction input, writeback and ALU-side output bundle of the decode stage.
interface i_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_opcode;
  logic [2:0]       out_funct3;
  logic [11:0]      out_imm;
  logic [XLEN-1:0]  out_in1;
  logic [4:0]       out_rd;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct3, out_imm, out_in1,
           out_rd, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_opcode, out_funct3, out_imm, out_in1,
           out_rd, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/i_regfile.sv
// Architectural register file: one async read, one write port, x0 reads zero.
module i_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);
  logic [XLEN-1:0] regs_q [NREGS];

  // Register array; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : regs_q[raddr_i];
endmodule

// File: rtl/i_decode_stage.sv
// OP-IMM decode/operand-fetch stage with a one-entry output slot.
// Optional macro I_DECODE_BYPASS_EN forwards same-cycle writebacks into rs1.
module i_decode_stage
  import i_type_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  i_decode_stage_if.slave  bus
);
  slot_e            state_q, state_d;
  dec_t             dec_s;
  logic             accept_s;
  logic [XLEN-1:0]  rf_rdata_s;
  logic [XLEN-1:0]  operand_s;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [11:0]      imm_q, imm_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  in1_q, in1_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign dec_s        = decode_instr(bus.in_instr);
  assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept_s     = bus.in_valid && bus.in_ready;

  i_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.wb_en),
    .waddr_i (bus.wb_rd),
    .wdata_i (bus.wb_data),
    .raddr_i (dec_s.rs1),
    .rdata_o (rf_rdata_s)
  );

`ifdef I_DECODE_BYPASS_EN
  logic [4:0] rs1_q, rs1_d;
  logic       hold_hit_s;

  assign operand_s  = (bus.wb_en && (bus.wb_rd == dec_s.rs1) && (dec_s.rs1 != 5'd0))
                      ? bus.wb_data : rf_rdata_s;
  // A stalled slot tracks writebacks to its own source register.
  assign hold_hit_s = (state_q == FULL) && !bus.out_ready && bus.wb_en &&
                      (bus.wb_rd == rs1_q) && (rs1_q != 5'd0);
  assign rs1_d      = accept_s ? dec_s.rs1 : rs1_q;

  // Held source register index for the stall-time bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q <= 5'd0;
    end else begin
      rs1_q <= rs1_d;
    end
  end
`else
  assign operand_s = rf_rdata_s;
`endif

  // Slot next-state, payload capture and saturating illegal counter.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    in1_d     = in1_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      EMPTY:   state_d = accept_s ? FULL : EMPTY;
      FULL:    state_d = (bus.out_ready && !accept_s) ? EMPTY : FULL;
      default: state_d = EMPTY;
    endcase
    if (accept_s) begin
      opcode_d  = dec_s.opcode;
      funct3_d  = dec_s.funct3;
      imm_d     = dec_s.imm;
      rd_d      = dec_s.rd;
      in1_d     = operand_s;
      illegal_d = dec_s.illegal;
`ifdef I_DECODE_BYPASS_EN
    end else if (hold_hit_s) begin
      in1_d = bus.wb_data;
`endif
    end else begin
      in1_d = in1_q;
    end
    if (accept_s && dec_s.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot state, payload and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
      imm_q     <= 12'd0;
      rd_q      <= 5'd0;
      in1_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      in1_q     <= in1_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid   = (state_q == FULL);
  assign bus.out_opcode  = opcode_q;
  assign bus.out_funct3  = funct3_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_in1     = in1_q;
  assign bus.out_illegal = illegal_q;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_i_decode_stage.sv
// Scoreboard bench for i_decode_stage: a 16-bit-counter instance plus a 2-bit-counter twin.
module tb_i_decode_stage;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mregs [32];
  logic [15:0] cnt_m;
  logic [1:0]  cnt2_m;
  logic        exp_ill;

  i_decode_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
  i_decode_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.wb_en     = bus.wb_en;
  assign bus2.wb_rd     = bus.wb_rd;
  assign bus2.wb_data   = bus.wb_data;
  assign bus2.out_ready = bus.out_ready;

  i_decode_stage #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  i_decode_stage #(.XLEN(32), .NREGS(32), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    cnt_m  = 16'd0;
    cnt2_m = 2'd0;
  endtask

  task automatic send(input logic [31:0] instr, input logic ill);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    exp_ill      = ill;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_instr = 32'd0;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'd0;
  endtask

  // One clock: check outputs at the falling edge, update the model, advance past the rising edge.
  task automatic cycle();
    exp_t e;
    logic acc;
    logic [4:0] rs1;
    @(negedge clk);
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (exp_q.size() == 0) || bus.out_ready});
    chk("illegal_cnt", {48'd0, bus.illegal_cnt}, {48'd0, cnt_m});
    chk("illegal_cnt_w2", {62'd0, bus2.illegal_cnt}, {62'd0, cnt2_m});
    if (exp_q.size() != 0 && bus.out_valid) begin
      chk("out_opcode",  {57'd0, bus.out_opcode},  {57'd0, exp_q[0].op});
      chk("out_funct3",  {61'd0, bus.out_funct3},  {61'd0, exp_q[0].f3});
      chk("out_imm",     {52'd0, bus.out_imm},     {52'd0, exp_q[0].imm});
      chk("out_in1",     {32'd0, bus.out_in1},     {32'd0, exp_q[0].in1});
      chk("out_rd",      {59'd0, bus.out_rd},      {59'd0, exp_q[0].rd});
      chk("out_illegal", {63'd0, bus.out_illegal}, {63'd0, exp_q[0].ill});
    end
    acc = bus.in_valid && ((exp_q.size() == 0) || bus.out_ready);
    if (exp_q.size() != 0 && bus.out_ready) begin
      void'(exp_q.pop_front());
`ifdef I_DECODE_BYPASS_EN
    end else if (exp_q.size() != 0 && bus.wb_en && bus.wb_rd == exp_q[0].rs1 && exp_q[0].rs1 != 5'd0) begin
      exp_q[0].in1 = bus.wb_data;
`endif
    end
    if (acc) begin
      rs1   = bus.in_instr[19:15];
      e.op  = bus.in_instr[6:0];
      e.f3  = bus.in_instr[14:12];
      e.imm = bus.in_instr[31:20];
      e.rd  = bus.in_instr[11:7];
      e.rs1 = rs1;
      e.ill = exp_ill;
      if (rs1 == 5'd0) e.in1 = 32'd0;
`ifdef I_DECODE_BYPASS_EN
      else if (bus.wb_en && bus.wb_rd == rs1) e.in1 = bus.wb_data;
`endif
      else e.in1 = mregs[rs1];
      exp_q.push_back(e);
      if (exp_ill) begin
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        if (cnt2_m != 2'b11) cnt2_m = cnt2_m + 2'd1;
      end
    end
    if (bus.wb_en && bus.wb_rd != 5'd0) mregs[bus.wb_rd] = bus.wb_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_ill = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle_in();
    model_reset();
    #2 rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Basic decode: x5 = 0xFF, then addi x5,x5,5.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_00FF;
    cycle();
    idle_in();
    send(32'h0052_8293, 1'b0);
    cycle();
    idle_in();
    chk("first_in1", {32'd0, bus.out_in1}, 64'h0000_00FF);
    cycle();

    // Backpressure: stall three cycles, a second instr waits, both drain in order.
    bus.out_ready = 1'b0;
    send(enc(12'h001, 5'd5, 3'd0, 5'd6), 1'b0);
    cycle();
    idle_in();
    for (int i = 0; i < 3; i++) cycle();
    send(enc(12'h7FF, 5'd0, 3'd7, 5'd7), 1'b0);
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    idle_in();
    cycle();
    cycle();

    // Same-cycle writeback to rs1 while accepting.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hDEAD_BEEF;
    send(enc(12'h010, 5'd1, 3'd4, 5'd2), 1'b0);
    cycle();
    idle_in();
`ifdef I_DECODE_BYPASS_EN
    chk("bypass_in1", {32'd0, bus.out_in1}, 64'hDEAD_BEEF);
`else
    chk("nobypass_in1", {32'd0, bus.out_in1}, 64'h0);
`endif
    cycle();

    // Writeback to x1 while a reader of x1 is stalled in the slot.
    bus.out_ready = 1'b0;
    send(enc(12'h020, 5'd1, 3'd6, 5'd3), 1'b0);
    cycle();
    idle_in();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h5555_AAAA;
    cycle();
    idle_in();
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Writes to x0 are dropped.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h0000_1234;
    cycle();
    idle_in();
    send(enc(12'h003, 5'd0, 3'd0, 5'd8), 1'b0);
    cycle();
    idle_in();
    chk("x0_in1", {32'd0, bus.out_in1}, 64'h0);
    cycle();

    // Illegal encodings flow through and are counted.
    send(32'h4000_1013, 1'b1);
    cycle();
    send(32'h0000_0033, 1'b1);
    cycle();
    idle_in();
    chk("cnt_two", {48'd0, bus.illegal_cnt}, 64'd2);
    send(32'h4000_5013, 1'b0);
    cycle();
    send(32'h0200_5013, 1'b1);
    cycle();
    for (int i = 0; i < 6; i++) begin
      send(32'h0000_0033, 1'b1);
      cycle();
    end
    idle_in();
    cycle();
    chk("cnt_w2_sat", {62'd0, bus2.illegal_cnt}, 64'd3);
    chk("cnt_w16", {48'd0, bus.illegal_cnt}, 64'd9);

    // Asynchronous reset while stalled and full.
    bus.out_ready = 1'b0;
    send(32'h0000_0033, 1'b1);
    cycle();
    idle_in();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_cnt", {48'd0, bus.illegal_cnt}, 64'd0);
    model_reset();
    bus.out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();
    send(enc(12'h001, 5'd5, 3'd0, 5'd5), 1'b0);
    cycle();
    idle_in();
    chk("x5_after_rst", {32'd0, bus.out_in1}, 64'h0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
